// File: rtl/spi_frame_sequencer_pkg.sv
//------------------------------------------------------------------------------
// spi_frame_sequencer_pkg
// Shared state encoding and header field positions for the SPI frame sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package spi_frame_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DROP    = 2'd2
    } seq_state_t;

    localparam int CMD_MSB = 15;
    localparam int CMD_LSB = 8;
    localparam int LEN_MSB = 7;
    localparam int LEN_LSB = 0;

endpackage

`default_nettype wire

// File: rtl/spi_word_fifo.sv
//------------------------------------------------------------------------------
// spi_word_fifo
// First-word fall-through 16-bit FIFO; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_word_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [15:0]                push_data,
    input  logic                       pop,
    output logic [15:0]                pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_push;

    assign empty  = (r_count == '0);
    assign full   = (r_count == CW'(DEPTH));
    assign count  = r_count;
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    // Head is forced to zero while empty so the output is defined from reset.
    assign pop_data = empty ? 16'h0000 : r_mem[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_frame_sequencer.sv
//------------------------------------------------------------------------------
// spi_frame_sequencer
// Splits received SPI words into header (cmd/len) and payload frames and
// queues the payload in a word FIFO.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_frame_sequencer
    import spi_frame_sequencer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cs_n,
    input  logic        word_valid,
    input  logic [15:0] word_data,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  cmd,
    output logic        frame_start,
    output logic        frame_done,
    output logic        busy,
    output logic        err_overflow,
    output logic        err_abort,
    input  logic        err_clear
);

    localparam int CW = $clog2(DEPTH + 1);

    seq_state_t    r_state, w_state_nxt;
    logic [7:0]    r_remaining, w_remaining_nxt;
    logic [7:0]    r_cmd, w_cmd_nxt;
    logic          r_frame_start, w_frame_start_nxt;
    logic          r_frame_done, w_frame_done_nxt;
    logic          r_err_overflow, w_err_overflow_nxt;
    logic          r_err_abort, w_err_abort_nxt;
    logic          w_push;
    logic          w_pop;
    logic          w_accept;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count_unused;
    logic [7:0]    w_len;

    assign w_len    = word_data[LEN_MSB:LEN_LSB];
    assign w_pop    = out_valid && out_ready;
    assign w_accept = !w_fifo_full || w_pop;

    spi_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (word_data),
        .pop       (w_pop),
        .pop_data  (out_data),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count_unused)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_remaining    <= '0;
            r_cmd          <= '0;
            r_frame_start  <= 1'b0;
            r_frame_done   <= 1'b0;
            r_err_overflow <= 1'b0;
            r_err_abort    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_remaining    <= w_remaining_nxt;
            r_cmd          <= w_cmd_nxt;
            r_frame_start  <= w_frame_start_nxt;
            r_frame_done   <= w_frame_done_nxt;
            r_err_overflow <= w_err_overflow_nxt;
            r_err_abort    <= w_err_abort_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_remaining_nxt    = r_remaining;
        w_cmd_nxt          = r_cmd;
        w_frame_start_nxt  = 1'b0;
        w_frame_done_nxt   = 1'b0;
        w_push             = 1'b0;
        // Clear first so that a same-cycle error set below takes priority.
        w_err_overflow_nxt = r_err_overflow && !err_clear;
        w_err_abort_nxt    = r_err_abort && !err_clear;

        case (r_state)
            ST_IDLE: begin
                if (!cs_n && word_valid) begin
                    w_cmd_nxt         = word_data[CMD_MSB:CMD_LSB];
                    w_remaining_nxt   = w_len;
                    w_frame_start_nxt = 1'b1;
                    if (w_len == 8'd0) begin
                        w_frame_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (cs_n) begin
                    w_err_abort_nxt = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end else if (word_valid) begin
                    if (w_accept) begin
                        w_push          = 1'b1;
                        w_remaining_nxt = r_remaining - 8'd1;
                        if (r_remaining == 8'd1) begin
                            w_frame_done_nxt = 1'b1;
                            w_state_nxt      = ST_IDLE;
                        end
                    end else begin
                        w_err_overflow_nxt = 1'b1;
                        w_state_nxt        = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (cs_n) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign out_valid    = !w_fifo_empty;
    assign cmd          = r_cmd;
    assign frame_start  = r_frame_start;
    assign frame_done   = r_frame_done;
    assign busy         = (r_state != ST_IDLE);
    assign err_overflow = r_err_overflow;
    assign err_abort    = r_err_abort;

endmodule

`default_nettype wire

// File: doc/spi_frame_sequencer.md
SPI_FRAME_SEQUENCER -- requirements
Module: spi_frame_sequencer

Interface
REQ-001 Parameter DEPTH, default 8, payload FIFO depth in 16-bit words; SHALL be a power of two, 2..64.
REQ-002 Port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Port cs_n, input, 1: SPI slave chip select, active low, already synchronous to clock; high = no frame.
REQ-005 Port word_valid, input, 1: one-cycle strobe; a complete 16-bit word is present on word_data.
REQ-006 Port word_data, input, 16: received SPI word, sampled only when word_valid=1.
REQ-007 Port out_data, output, 16: FIFO head word.
REQ-008 Port out_valid, output, 1: FIFO non-empty.
REQ-009 Port out_ready, input, 1: consumer accepts head; pop when out_valid && out_ready.
REQ-010 Port cmd, output, 8: command byte of current/last frame.
REQ-011 Port frame_start, output, 1: one-cycle pulse on header accept.
REQ-012 Port frame_done, output, 1: one-cycle pulse on complete frame.
REQ-013 Port busy, output, 1: high in PAYLOAD or DROP.
REQ-014 Port err_overflow, output, 1: sticky; payload word lost to full FIFO.
REQ-015 Port err_abort, output, 1: sticky; cs_n rose before frame complete.
REQ-016 Port err_clear, input, 1: synchronous clear of both sticky errors.

Function
REQ-017 Frame format: first word after IDLE is header; header[15:8]=cmd, header[7:0]=len (payload word count, 0..255); then len payload words.
REQ-018 States: IDLE, PAYLOAD, DROP; busy=1 outside IDLE.
REQ-019 IDLE, word_valid=1, cs_n=0: latch cmd, remaining<=len, pulse frame_start next cycle; len=0 -> also pulse frame_done same cycle, stay IDLE; else -> PAYLOAD.
REQ-020 PAYLOAD, word_valid=1, push accepted: write word to FIFO, remaining decrements; on last word pulse frame_done, -> IDLE.
REQ-021 Push accepted if occupancy < DEPTH, or if a pop occurs in the same cycle (simultaneous push/pop when full is legal; occupancy unchanged).
REQ-022 PAYLOAD, word_valid=1, push not accepted: word discarded, err_overflow<=1, -> DROP; no frame_done for that frame.
REQ-023 DROP: ignore all word_valid; cs_n=1 -> IDLE.
REQ-024 PAYLOAD, cs_n=1 (word_valid ignored that cycle): err_abort<=1, -> IDLE; already pushed words remain in FIFO.
REQ-025 IDLE, cs_n=1: word_valid ignored.
REQ-026 Back-to-back frames within one cs_n low period are legal: word after frame_done is a new header.
REQ-027 FIFO: first-word fall-through; out_data valid whenever out_valid=1; pop-to-next-head latency 1 cycle; occupancy counter DEPTH+1 states, pointers wrap modulo DEPTH.
REQ-028 Pop never blocked by state; pops continue in all states.
REQ-029 err_clear and a same-cycle error set: set wins.
REQ-030 frame_start, frame_done registered, never high more than one cycle per event.

Reset
REQ-031 On reset: state IDLE, FIFO empty (out_valid=0), pointers 0, remaining 0, cmd=0, out_data=0, frame_start=0, frame_done=0, busy=0, err_overflow=0, err_abort=0.
REQ-032 Reset mid-frame discards FIFO contents and frame progress; first word_valid after release is a header.

Structure
REQ-033 Shared package/header: state encodings (IDLE=0, PAYLOAD=1, DROP=2), header field positions CMD_MSB=15, CMD_LSB=8, LEN_MSB=7, LEN_LSB=0.
REQ-034 One sub-module: spi_word_fifo (parameter DEPTH, 16-bit, FWFT, push/pop/full/empty/count); sequencer FSM in top level.

Verification
REQ-035 Header 0x2A03 then 0x1111, 0x2222, 0x3333, out_ready=1 -> frame_start once, cmd=0x2A, frame_done after third word, FIFO out 0x1111, 0x2222, 0x3333 in order.
REQ-036 Header 0x0500 -> frame_start and frame_done same cycle, state IDLE, FIFO empty; next word treated as header.
REQ-037 DEPTH=8, out_ready=0, header 0x010A, 10 payload words -> 8 stored, err_overflow=1 at 9th, no frame_done, busy until cs_n=1.
REQ-038 Header 0x0704, 2 words, cs_n=1 -> err_abort=1, IDLE, 2 words remain readable; err_clear -> both errors 0.
REQ-039 FIFO full, word_valid and out_ready same cycle -> push accepted, no overflow, occupancy stays 8.
REQ-040 Assert reset mid-PAYLOAD with 3 words queued -> all outputs per REQ-031 immediately; next word after release decoded as header.
